// File: rtl/ft245_fifo_responder_pkg.sv
// ft245_fifo_responder_pkg: shared FSM encodings, strobe idle level and default FIFO depth
package ft245_fifo_responder_pkg;
    localparam int         DEFAULT_DEPTH_LOG2 = 4;
    localparam logic       STROBE_IDLE        = 1'b1;
    localparam logic [1:0] R_IDLE             = 2'd0;
    localparam logic [1:0] R_DRIVE            = 2'd1;
    localparam logic [1:0] R_POP              = 2'd2;
    localparam logic [0:0] W_IDLE             = 1'b0;
    localparam logic [0:0] W_CAPTURE          = 1'b1;
endpackage

// File: rtl/ft245_fifo_responder_if.sv
// ft245_fifo_responder_if: FT245 pin bus plus host-side byte streams of the FTDI-side responder
interface ft245_fifo_responder_if;
    logic       ft_rd_n;
    logic       ft_wr_n;
    logic [7:0] ft_data_i;
    logic [7:0] ft_data_o;
    logic       ft_data_oe;
    logic       ft_rxf_n;
    logic       ft_txe_n;
    logic [7:0] h_rx_data;
    logic       h_rx_valid;
    logic       h_rx_ready;
    logic [7:0] h_tx_data;
    logic       h_tx_valid;
    logic       h_tx_ready;
    logic       err_underrun;
    logic       err_overflow;
    modport master (
        output ft_rd_n, ft_wr_n, ft_data_i, h_rx_data, h_rx_valid, h_tx_ready,
        input  ft_data_o, ft_data_oe, ft_rxf_n, ft_txe_n, h_rx_ready, h_tx_data, h_tx_valid,
               err_underrun, err_overflow
    );
    modport slave (
        input  ft_rd_n, ft_wr_n, ft_data_i, h_rx_data, h_rx_valid, h_tx_ready,
        output ft_data_o, ft_data_oe, ft_rxf_n, ft_txe_n, h_rx_ready, h_tx_data, h_tx_valid,
               err_underrun, err_overflow
    );
endinterface

// File: rtl/ft245_sync_fifo.sv
// ft245_sync_fifo: byte FIFO, first-word fall-through, extra pointer bit separates full from empty
module ft245_sync_fifo
    import ft245_fifo_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    logic [DEPTH_LOG2:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]          mem_q [2**DEPTH_LOG2];
    logic                push_ok, pop_ok;

    // status and pointer advance; a pop frees the slot a same-cycle push needs when full
    always_comb begin
        empty   = wptr_q == rptr_q;
        full    = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                  (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
        pop_ok  = pop & ~empty;
        push_ok = push & (~full | pop_ok);
        wptr_d  = wptr_q + {{DEPTH_LOG2{1'b0}}, push_ok};
        rptr_d  = rptr_q + {{DEPTH_LOG2{1'b0}}, pop_ok};
        rdata   = mem_q[rptr_q[DEPTH_LOG2-1:0]];
    end

    // pointer registers, cleared by reset so contents are discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // storage array, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wdata;
    end
endmodule

// File: rtl/ft245_fifo_responder.sv
// ft245_fifo_responder: FTDI-side peer of the CPLD FT245 master; RX/TX byte FIFOs behind RD#/WR#.
// Define FT245_LOOPBACK_EN to route captured CPLD writes back into the RX FIFO.
module ft245_fifo_responder
    import ft245_fifo_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
    parameter int SYNC_STAGES = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    ft245_fifo_responder_if.slave bus
);
    logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d, wr_sync_q, wr_sync_d, fill_q, fill_d;
    logic                   rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
    logic                   rd_arm_q, rd_arm_d, wr_arm_q, wr_arm_d, init_q, init_d;
    logic                   rd_s, wr_s, chain_ok, rd_fall, rd_rise, wr_fall;
    logic [1:0]             rstate_q, rstate_d;
    logic [0:0]             wstate_q, wstate_d;
    logic                   oe_q, oe_d, rxf_q, rxf_d, txe_q, txe_d, und_q, und_d, ovf_q, ovf_d;
    logic [7:0]             dout_q, dout_d;
    logic                   cap, h_rx_ready_c;
    logic                   rx_push, rx_pop, rx_full, rx_empty;
    logic                   tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]             rx_wdata, rx_rdata, tx_wdata, tx_rdata;

    // strobe synchronizers; edges are armed only after the real pin level has been seen high since reset
    always_comb begin
        rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], bus.ft_rd_n};
        wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], bus.ft_wr_n};
        fill_d    = {fill_q[SYNC_STAGES-2:0], 1'b1};
        chain_ok  = fill_q[SYNC_STAGES-1];
        rd_s      = rd_sync_q[SYNC_STAGES-1];
        wr_s      = wr_sync_q[SYNC_STAGES-1];
        rd_prev_d = rd_s;
        wr_prev_d = wr_s;
        rd_arm_d  = rd_arm_q | (chain_ok & rd_s);
        wr_arm_d  = wr_arm_q | (chain_ok & wr_s);
        rd_fall   = rd_arm_q & rd_prev_q & ~rd_s;
        rd_rise   = ~rd_prev_q & rd_s;
        wr_fall   = wr_arm_q & wr_prev_q & ~wr_s;
        init_d    = 1'b1;
    end

    // read FSM: snapshot RX head on the falling strobe, pop once the strobe is released
    always_comb begin
        rstate_d = rstate_q;
        oe_d     = oe_q;
        dout_d   = dout_q;
        und_d    = und_q;
        rx_pop   = 1'b0;
        case (rstate_q)
            R_IDLE: if (rd_fall) begin
                rstate_d = R_DRIVE;
                oe_d     = 1'b1;
                dout_d   = rx_empty ? 8'h00 : rx_rdata;
            end
            R_DRIVE: if (rd_rise) begin
                rstate_d = R_POP;
                oe_d     = 1'b0;
            end
            R_POP: begin
                rstate_d = R_IDLE;
                rx_pop   = ~rx_empty;
                und_d    = und_q | rx_empty;
            end
            default: begin
                rstate_d = R_IDLE;
                oe_d     = 1'b0;
            end
        endcase
    end

    // write FSM and FIFO steering; one capture per falling write strobe
    always_comb begin
        wstate_d = (wstate_q == W_IDLE && wr_fall) ? W_CAPTURE : W_IDLE;
        cap      = wstate_q == W_CAPTURE;
`ifdef FT245_LOOPBACK_EN
        h_rx_ready_c = init_q & ~rx_full & ~cap;
        rx_push      = cap | (bus.h_rx_valid & h_rx_ready_c);
        rx_wdata     = cap ? bus.ft_data_i : bus.h_rx_data;
        tx_push      = 1'b0;
        tx_wdata     = 8'h00;
        tx_pop       = 1'b0;
        ovf_d        = ovf_q | (cap & rx_full & ~rx_pop);
        txe_d        = rx_full;
`else
        h_rx_ready_c = init_q & ~rx_full;
        rx_push      = bus.h_rx_valid & h_rx_ready_c;
        rx_wdata     = bus.h_rx_data;
        tx_push      = cap;
        tx_wdata     = bus.ft_data_i;
        tx_pop       = bus.h_tx_ready & ~tx_empty;
        ovf_d        = ovf_q | (cap & tx_full & ~tx_pop);
        txe_d        = tx_full;
`endif
        rxf_d = rx_empty;
    end

    // drive the interface outputs
    always_comb begin
        bus.ft_data_o    = dout_q;
        bus.ft_data_oe   = oe_q;
        bus.ft_rxf_n     = rxf_q;
        bus.ft_txe_n     = txe_q;
        bus.h_rx_ready   = h_rx_ready_c;
        bus.err_underrun = und_q;
        bus.err_overflow = ovf_q;
`ifdef FT245_LOOPBACK_EN
        bus.h_tx_valid   = 1'b0;
        bus.h_tx_data    = 8'h00;
`else
        bus.h_tx_valid   = ~tx_empty;
        bus.h_tx_data    = tx_empty ? 8'h00 : tx_rdata;
`endif
    end

    // state registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sync_q <= {SYNC_STAGES{STROBE_IDLE}};
            wr_sync_q <= {SYNC_STAGES{STROBE_IDLE}};
            fill_q    <= '0;
            rd_prev_q <= STROBE_IDLE;
            wr_prev_q <= STROBE_IDLE;
            rd_arm_q  <= 1'b0;
            wr_arm_q  <= 1'b0;
            init_q    <= 1'b0;
            rstate_q  <= R_IDLE;
            wstate_q  <= W_IDLE;
            oe_q      <= 1'b0;
            dout_q    <= 8'h00;
            rxf_q     <= 1'b1;
            txe_q     <= 1'b1;
            und_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            rd_sync_q <= rd_sync_d;
            wr_sync_q <= wr_sync_d;
            fill_q    <= fill_d;
            rd_prev_q <= rd_prev_d;
            wr_prev_q <= wr_prev_d;
            rd_arm_q  <= rd_arm_d;
            wr_arm_q  <= wr_arm_d;
            init_q    <= init_d;
            rstate_q  <= rstate_d;
            wstate_q  <= wstate_d;
            oe_q      <= oe_d;
            dout_q    <= dout_d;
            rxf_q     <= rxf_d;
            txe_q     <= txe_d;
            und_q     <= und_d;
            ovf_q     <= ovf_d;
        end
    end

    ft245_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .wdata(rx_wdata), .pop(rx_pop),
        .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
    );

    ft245_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .wdata(tx_wdata), .pop(tx_pop),
        .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
    );
endmodule

// File: tb/tb_ft245_fifo_responder.sv
// tb_ft245_fifo_responder: directed bench for the FT245 responder; FT245_LOOPBACK_EN selects the loopback sequence
module tb_ft245_fifo_responder;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] d;
    logic       oe;

    ft245_fifo_responder_if bus();

    ft245_fifo_responder dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(output logic [7:0] dv, output logic oev);
        bus.ft_rd_n = 1'b0;
        repeat (3) @(negedge clk);
        dv  = bus.ft_data_o;
        oev = bus.ft_data_oe;
        repeat (3) @(negedge clk);
        bus.ft_rd_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] b);
        bus.ft_data_i = b;
        bus.ft_wr_n   = 1'b0;
        repeat (4) @(negedge clk);
        bus.ft_wr_n   = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic host_push(input logic [7:0] b);
        bus.h_rx_data  = b;
        bus.h_rx_valid = 1'b1;
        @(negedge clk);
        bus.h_rx_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.ft_rd_n    = 1'b1;
        bus.ft_wr_n    = 1'b1;
        bus.ft_data_i  = 8'h00;
        bus.h_rx_data  = 8'h00;
        bus.h_rx_valid = 1'b0;
        bus.h_tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_oe", 32'(bus.ft_data_oe), 0);
        chk("rst_data_o", 32'(bus.ft_data_o), 0);
        chk("rst_rxf_n", 32'(bus.ft_rxf_n), 1);
        chk("rst_txe_n", 32'(bus.ft_txe_n), 1);
        chk("rst_rx_ready", 32'(bus.h_rx_ready), 0);
        chk("rst_tx_valid", 32'(bus.h_tx_valid), 0);
        chk("rst_tx_data", 32'(bus.h_tx_data), 0);
        chk("rst_errs", 32'({bus.err_underrun, bus.err_overflow}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_txe_n", 32'(bus.ft_txe_n), 0);
        chk("post_rst_rx_ready", 32'(bus.h_rx_ready), 1);
        repeat (4) @(negedge clk);
`ifdef FT245_LOOPBACK_EN
        do_write(8'hA5);
        chk("lb_rxf_n", 32'(bus.ft_rxf_n), 0);
        chk("lb_tx_valid", 32'(bus.h_tx_valid), 0);
        do_read(d, oe);
        chk("lb_read_oe", 32'(oe), 1);
        chk("lb_read_data", 32'(d), 'hA5);
        chk("lb_rxf_n_after", 32'(bus.ft_rxf_n), 1);
        chk("lb_tx_valid_after", 32'(bus.h_tx_valid), 0);
`else
        // single host byte, one long CPLD read
        host_push(8'h5A);
        chk("t1_rxf_lag", 32'(bus.ft_rxf_n), 1);
        @(negedge clk);
        chk("t1_rxf_n", 32'(bus.ft_rxf_n), 0);
        bus.ft_rd_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t1_oe_early", 32'(bus.ft_data_oe), 0);
        @(negedge clk);
        chk("t1_oe_clk3", 32'(bus.ft_data_oe), 1);
        chk("t1_data_clk3", 32'(bus.ft_data_o), 'h5A);
        repeat (7) @(negedge clk);
        chk("t1_oe_held", 32'(bus.ft_data_oe), 1);
        chk("t1_data_held", 32'(bus.ft_data_o), 'h5A);
        bus.ft_rd_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t1_oe_off", 32'(bus.ft_data_oe), 0);
        chk("t1_rxf_n_empty", 32'(bus.ft_rxf_n), 1);
        chk("t1_underrun", 32'(bus.err_underrun), 0);
        // single CPLD write, host drain
        do_write(8'hC3);
        chk("t2_tx_valid", 32'(bus.h_tx_valid), 1);
        chk("t2_tx_data", 32'(bus.h_tx_data), 'hC3);
        bus.h_tx_ready = 1'b1;
        @(negedge clk);
        bus.h_tx_ready = 1'b0;
        chk("t2_tx_valid_after", 32'(bus.h_tx_valid), 0);
        // fill RX from host, read it all back plus one underrun
        for (int i = 0; i < 16; i++) host_push(8'(i));
        chk("t3_rx_ready_full", 32'(bus.h_rx_ready), 0);
        chk("t3_rxf_n", 32'(bus.ft_rxf_n), 0);
        for (int i = 0; i < 16; i++) begin
            do_read(d, oe);
            chk($sformatf("t3_read_%0d", i), 32'(d), i);
            chk($sformatf("t3_oe_%0d", i), 32'(oe), 1);
        end
        chk("t3_underrun_before", 32'(bus.err_underrun), 0);
        chk("t3_rx_ready_empty", 32'(bus.h_rx_ready), 1);
        do_read(d, oe);
        chk("t3_read_empty", 32'(d), 0);
        chk("t3_underrun", 32'(bus.err_underrun), 1);
        chk("t3_rxf_n_empty", 32'(bus.ft_rxf_n), 1);
        // overfill TX from the CPLD, then drain in order
        for (int i = 0; i < 16; i++) do_write(8'('h80 + i));
        chk("t4_txe_n_full", 32'(bus.ft_txe_n), 1);
        chk("t4_overflow_before", 32'(bus.err_overflow), 0);
        do_write(8'hEE);
        chk("t4_overflow", 32'(bus.err_overflow), 1);
        bus.h_tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t4_drain_%0d", i), 32'(bus.h_tx_data), 'h80 + i);
            @(negedge clk);
        end
        bus.h_tx_ready = 1'b0;
        chk("t4_tx_valid_drained", 32'(bus.h_tx_valid), 0);
        @(negedge clk);
        chk("t4_txe_n_drained", 32'(bus.ft_txe_n), 0);
        // reset in the middle of a read
        host_push(8'h77);
        bus.ft_rd_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_oe_drive", 32'(bus.ft_data_oe), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_oe_async", 32'(bus.ft_data_oe), 0);
        chk("t5_rxf_n", 32'(bus.ft_rxf_n), 1);
        chk("t5_errs_clr", 32'({bus.err_underrun, bus.err_overflow}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_no_spurious_oe", 32'(bus.ft_data_oe), 0);
        chk("t5_rx_ready", 32'(bus.h_rx_ready), 1);
        bus.ft_rd_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_oe_after_rise", 32'(bus.ft_data_oe), 0);
        chk("t5_underrun_after_rise", 32'(bus.err_underrun), 0);
        chk("t5_rxf_n_after", 32'(bus.ft_rxf_n), 1);
        host_push(8'h3C);
        @(negedge clk);
        do_read(d, oe);
        chk("t5_fresh_read", 32'(d), 'h3C);
        chk("t5_fresh_underrun", 32'(bus.err_underrun), 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
